// File: rtl/fir_ctrl_if.sv
// fir_ctrl_if
//   Handshake bundle between a sample/coefficient source and fir_ctrl.
//   Carries three streams:
//     in_*       : sample stream into the filter (valid/ready)
//     cfg_*      : coefficient write stream (valid/ready) plus the
//                  end-of-load commit pulse
//     out_*      : filtered result stream (valid only, no backpressure)
//   master modport : the source/sink side (testbench or upstream logic)
//   slave modport  : fir_ctrl itself
interface fir_ctrl_if #(
  parameter int AW = 3
);
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               in_ready;

  logic               cfg_valid;
  logic [AW-1:0]      cfg_addr;
  logic signed [15:0] cfg_data;
  logic               cfg_ready;
  logic               cfg_commit;

  logic               out_valid;
  logic signed [31:0] out_data;

  modport master (
    output in_valid, in_data, cfg_valid, cfg_addr, cfg_data, cfg_commit,
    input  in_ready, cfg_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, cfg_valid, cfg_addr, cfg_data, cfg_commit,
    output in_ready, cfg_ready, out_valid, out_data
  );
endinterface

// File: rtl/fir_ctrl.sv
// fir_ctrl
//   Controller wrapped around an external pipelined FIR that advances one
//   sample every clock. It gates the sample stream, forwards coefficient
//   writes through a registered write port, zero-flushes the FIR after
//   reset and after every coefficient load, and tags which FIR outputs
//   belong to real accepted samples.
//
//   Ports
//     clk, rst       : rising-edge clock, synchronous active-high reset
//     bus (slave)    : in_*/cfg_*/out_* handshake bundle (fir_ctrl_if)
//     fir_data_in    : sample presented to the FIR (zero in gaps/flush)
//     fir_coef_we/addr/data : registered coefficient write port to FIR
//     fir_data_out   : FIR result, passed straight through to out_data
//     busy           : high whenever the controller is not in RUN
module fir_ctrl #(
  parameter  int NTAPS     = 8,
  parameter  int LAT       = 4,
  parameter  int FLUSH_LEN = NTAPS + LAT,
  localparam int AW        = $clog2(NTAPS),
  localparam int CW        = $clog2(FLUSH_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  fir_ctrl_if.slave          bus,
  output logic signed [15:0] fir_data_in,
  output logic               fir_coef_we,
  output logic [AW-1:0]      fir_coef_addr,
  output logic signed [15:0] fir_coef_data,
  input  logic signed [31:0] fir_data_out,
  output logic               busy
);

  typedef enum logic [1:0] {RUN, LOAD, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LAT-1:0]     vsr_q, vsr_d;
  logic               coef_we_q, coef_we_d;
  logic [AW-1:0]      coef_addr_q, coef_addr_d;
  logic signed [15:0] coef_data_q, coef_data_d;

  logic cfg_ready;
  logic in_ready;
  logic cfg_accept;
  logic in_accept;

  // Configuration wins over data in the same cycle, so a sample is never
  // accepted in the cycle that kicks the controller into LOAD.
  assign cfg_ready  = (state_q != FLUSH);
  assign in_ready   = (state_q == RUN) && !bus.cfg_valid;
  assign cfg_accept = bus.cfg_valid && cfg_ready;
  assign in_accept  = bus.in_valid && in_ready;

  assign bus.cfg_ready = cfg_ready;
  assign bus.in_ready  = in_ready;

  // The FIR advances every cycle, so anything that is not an accepted
  // sample must enter it as a zero.
  assign fir_data_in   = in_accept ? bus.in_data : 16'sd0;

  assign bus.out_valid = vsr_q[LAT-1];
  assign bus.out_data  = fir_data_out;

  assign fir_coef_we   = coef_we_q;
  assign fir_coef_addr = coef_addr_q;
  assign fir_coef_data = coef_data_q;

  assign busy = (state_q != RUN);

  // Next-state logic. The valid shift register follows accepted samples
  // through the FIR latency; it is wiped when leaving RUN so results that
  // were computed with the old coefficients are never flagged valid.
  // The flush counter holds at its terminal value rather than wrapping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vsr_d       = (vsr_q << 1) | LAT'(in_accept);
    coef_we_d   = cfg_accept;
    coef_addr_d = cfg_accept ? bus.cfg_addr : coef_addr_q;
    coef_data_d = cfg_accept ? bus.cfg_data : coef_data_q;

    case (state_q)
      RUN: begin
        if (cfg_accept) begin
          state_d = LOAD;
          vsr_d   = '0;
        end
      end
      LOAD: begin
        if (bus.cfg_commit) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        if (cnt_q == CW'(FLUSH_LEN - 1)) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = FLUSH;
        cnt_d   = '0;
        vsr_d   = '0;
      end
    endcase
  end

  // State registers. Reset restarts the flush and drops any coefficient
  // write that was accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FLUSH;
      cnt_q       <= '0;
      vsr_q       <= '0;
      coef_we_q   <= 1'b0;
      coef_addr_q <= '0;
      coef_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vsr_q       <= vsr_d;
      coef_we_q   <= coef_we_d;
      coef_addr_q <= coef_addr_d;
      coef_data_q <= coef_data_d;
    end
  end

endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl
//   Drives fir_ctrl with a behavioural pipelined FIR attached, and checks
//   reset/flush timing, coefficient loading, sample-to-result latency and
//   data, configuration priority, ignored commits and reset mid-flush.
module tb_fir_ctrl;
  localparam int NTAPS     = 8;
  localparam int LAT       = 4;
  localparam int FLUSH_LEN = NTAPS + LAT;
  localparam int AW        = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_ctrl_if #(.AW(AW)) bus ();

  logic signed [15:0] fir_data_in;
  logic               fir_coef_we;
  logic [AW-1:0]      fir_coef_addr;
  logic signed [15:0] fir_coef_data;
  logic signed [31:0] fir_data_out;
  logic               busy;

  fir_ctrl #(.NTAPS(NTAPS), .LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .fir_data_in  (fir_data_in),
    .fir_coef_we  (fir_coef_we),
    .fir_coef_addr(fir_coef_addr),
    .fir_coef_data(fir_coef_data),
    .fir_data_out (fir_data_out),
    .busy         (busy)
  );

  // Behavioural FIR: coefficient memory, sample history, LAT-stage output pipe.
  logic signed [15:0] fir_coef_mem [NTAPS];
  logic signed [15:0] fir_hist     [NTAPS];
  logic signed [31:0] fir_pipe     [LAT];

  initial begin
    for (int i = 0; i < NTAPS; i++) begin
      fir_coef_mem[i] = '0;
      fir_hist[i]     = '0;
    end
    for (int k = 0; k < LAT; k++) fir_pipe[k] = '0;
  end

  always @(posedge clk) begin : fir_model
    logic signed [31:0] acc;
    for (int i = NTAPS - 1; i > 0; i--) fir_hist[i] = fir_hist[i-1];
    fir_hist[0] = fir_data_in;
    acc = '0;
    for (int i = 0; i < NTAPS; i++)
      acc = acc + 32'(fir_coef_mem[i]) * 32'(fir_hist[i]);
    for (int k = LAT - 1; k > 0; k--) fir_pipe[k] <= fir_pipe[k-1];
    fir_pipe[0] <= acc;
    if (fir_coef_we) fir_coef_mem[fir_coef_addr] <= fir_coef_data;
  end

  assign fir_data_out = fir_pipe[LAT-1];

  // Scoreboard and bookkeeping
  typedef struct {
    logic signed [31:0] data;
    int                 cyc;
  } exp_t;

  exp_t               sb_q[$];
  logic [AW+15:0]     coef_log[$];
  logic signed [15:0] ref_coef [NTAPS];
  logic signed [15:0] ref_hist [NTAPS];
  logic signed [15:0] vals_ramp[NTAPS];
  logic signed [15:0] vals_ones[NTAPS];
  int cyc          = 0;
  int tests_run    = 0;
  int tests_failed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every out_valid must match the oldest expectation, both
  // in value and in arrival exactly LAT cycles after its acceptance.
  always @(negedge clk) begin : out_monitor
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_out_valid: got out_data=%0d at cycle %0d, required no output", bus.out_data, cyc);
      end else begin
        e = sb_q.pop_front();
        if (bus.out_data !== e.data || (cyc - e.cyc) != LAT) begin
          tests_failed++;
          $display("[TB] FAIL out_data: got %0d after %0d cycles, required %0d after %0d cycles",
                   bus.out_data, cyc - e.cyc, e.data, LAT);
        end
      end
    end
  end

  always @(negedge clk) if (fir_coef_we === 1'b1) coef_log.push_back({fir_coef_addr, fir_coef_data});

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic signed [31:0] ref_out();
    logic signed [31:0] acc;
    acc = '0;
    for (int i = 0; i < NTAPS; i++) acc = acc + 32'(ref_coef[i]) * 32'(ref_hist[i]);
    return acc;
  endfunction

  // One FIR cycle of sample stimulus; accepted samples queue their result.
  task automatic step_sample(input logic v, input logic signed [15:0] d);
    exp_t e;
    @(posedge clk); #1;
    bus.in_valid = v;
    bus.in_data  = d;
    for (int i = NTAPS - 1; i > 0; i--) ref_hist[i] = ref_hist[i-1];
    ref_hist[0] = v ? d : 16'sd0;
    if (v) begin
      e.data = ref_out();
      e.cyc  = cyc;
      sb_q.push_back(e);
      #1;
      tests_run++;
      if (bus.in_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL in_ready_run: got %b, required 1", bus.in_ready);
      end
    end
  endtask

  // Counts edges until busy drops, offering junk samples meanwhile; none may
  // leak into the FIR and no handshake may be granted while flushing.
  task automatic wait_run(input int expected, input string name);
    int   n;
    logic bad;
    n   = 0;
    bad = 1'b0;
    while (n < 100) begin
      @(posedge clk); #1;
      bus.cfg_commit = 1'b0;
      bus.cfg_valid  = 1'b0;
      bus.in_valid   = 1'b1;
      bus.in_data    = 16'sh1111;
      #1;
      n++;
      if (busy === 1'b0) break;
      if (bus.in_ready !== 1'b0 || bus.cfg_ready !== 1'b0 || bus.out_valid !== 1'b0 || fir_data_in !== 16'sd0)
        bad = 1'b1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int i = 0; i < NTAPS; i++) ref_hist[i] = '0;
    tests_run++;
    if (n != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s_cycles: got %0d, required %0d", name, n, expected);
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("[TB] FAIL %s_flush_quiet: got handshake/data activity during flush, required none", name);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.cfg_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got busy=%b in_ready=%b cfg_ready=%b out_valid=%b, required 1 0 0 0",
               busy, bus.in_ready, bus.cfg_ready, bus.out_valid);
    end
    tests_run++;
    if (fir_coef_we !== 1'b0 || fir_coef_addr !== '0 || fir_coef_data !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_coef_port: got we=%b addr=%0d data=%0d, required 0 0 0",
               fir_coef_we, fir_coef_addr, fir_coef_data);
    end
    rst = 1'b0;
    wait_run(FLUSH_LEN, "reset_release");
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.cfg_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL run_ready: got in_ready=%b cfg_ready=%b, required 1 1", bus.in_ready, bus.cfg_ready);
    end
  endtask

  task automatic test_coef_load(input logic signed [15:0] vals [NTAPS], input string name);
    coef_log.delete();
    for (int i = 0; i < NTAPS; i++) begin
      @(posedge clk); #1;
      bus.cfg_valid = 1'b1;
      bus.cfg_addr  = AW'(i);
      bus.cfg_data  = vals[i];
      #1;
      tests_run++;
      if (bus.cfg_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL %s_cfg_ready[%0d]: got %b, required 1", name, i, bus.cfg_ready);
      end
    end
    @(posedge clk); #1;
    bus.cfg_valid  = 1'b0;
    bus.cfg_commit = 1'b1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s_load_busy: got %b, required 1", name, busy);
    end
    wait_run(FLUSH_LEN + 1, name);
    tests_run++;
    if (coef_log.size() != NTAPS) begin
      tests_failed++;
      $display("[TB] FAIL %s_pulse_count: got %0d, required %0d", name, coef_log.size(), NTAPS);
    end else begin
      for (int i = 0; i < NTAPS; i++) begin
        tests_run++;
        if (coef_log[i] !== {AW'(i), vals[i]}) begin
          tests_failed++;
          $display("[TB] FAIL %s_pulse[%0d]: got addr=%0d data=%0d, required addr=%0d data=%0d",
                   name, i, coef_log[i][AW+15:16], $signed(coef_log[i][15:0]), i, vals[i]);
        end
      end
    end
    for (int i = 0; i < NTAPS; i++) ref_coef[i] = vals[i];
  endtask

  task automatic drain_and_check(input string name);
    repeat (LAT + NTAPS) step_sample(1'b0, 16'sd0);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s_drain: got %0d results missing, required 0", name, sb_q.size());
    end
  endtask

  task automatic test_impulse(input string name);
    step_sample(1'b1, 16'sd32767);
    repeat (NTAPS + 3) step_sample(1'b1, 16'sd0);
    drain_and_check(name);
  endtask

  task automatic test_gaps();
    step_sample(1'b1, 16'sd100);
    step_sample(1'b0, 16'sd0);
    step_sample(1'b1, -16'sd200);
    step_sample(1'b1, 16'sd300);
    step_sample(1'b0, 16'sd0);
    step_sample(1'b0, 16'sd0);
    step_sample(1'b1, -16'sd32768);
    step_sample(1'b1, 16'sd32767);
    step_sample(1'b1, 16'sd5);
    drain_and_check("gaps");
  endtask

  task automatic test_cfg_priority();
    // This sample is in flight when configuration starts, so it is discarded.
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd1234;
    @(posedge clk); #1;
    bus.in_data   = 16'sd77;
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 3'd3;
    bus.cfg_data  = 16'sd5;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b0 || bus.cfg_ready !== 1'b1 || fir_data_in !== 16'sd0) begin
      tests_failed++;
      $display("[TB] FAIL prio_handshake: got in_ready=%b cfg_ready=%b fir_data_in=%0d, required 0 1 0",
               bus.in_ready, bus.cfg_ready, fir_data_in);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.cfg_valid = 1'b0;
    tests_run++;
    if (fir_coef_we !== 1'b1 || fir_coef_addr !== 3'd3 || fir_coef_data !== 16'sd5 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL prio_write: got we=%b addr=%0d data=%0d busy=%b, required 1 3 5 1",
               fir_coef_we, fir_coef_addr, fir_coef_data, busy);
    end
    @(posedge clk); #1;
    tests_run++;
    if (fir_coef_we !== 1'b0 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL prio_single_pulse: got we=%b in_ready=%b, required 0 0", fir_coef_we, bus.in_ready);
    end
    repeat (LAT + 1) @(posedge clk);
    #1;
    bus.cfg_commit = 1'b1;
    wait_run(FLUSH_LEN + 1, "prio_commit");
    ref_coef[3] = 16'sd5;
  endtask

  task automatic test_commit_in_run();
    @(posedge clk); #1;
    bus.cfg_commit = 1'b1;
    @(posedge clk); #1;
    bus.cfg_commit = 1'b0;
    repeat (3) begin
      tests_run++;
      if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL commit_in_run: got busy=%b in_ready=%b, required 0 1", busy, bus.in_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_flush();
    int log_size;
    // Reset in the same cycle as an accepted write drops that write.
    log_size = coef_log.size();
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 3'd5;
    bus.cfg_data  = 16'sd99;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    tests_run++;
    if (fir_coef_we !== 1'b0 || fir_coef_addr !== 3'd0 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_drop_write: got we=%b addr=%0d busy=%b, required 0 0 1", fir_coef_we, fir_coef_addr, busy);
    end
    rst = 1'b0;
    wait_run(FLUSH_LEN, "reset_in_run");
    tests_run++;
    if (coef_log.size() != log_size) begin
      tests_failed++;
      $display("[TB] FAIL reset_drop_log: got %0d pulses, required %0d", coef_log.size(), log_size);
    end
    // Load one coefficient, commit, then reset partway through the flush.
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 3'd0;
    bus.cfg_data  = 16'sd9;
    @(posedge clk); #1;
    bus.cfg_valid  = 1'b0;
    bus.cfg_commit = 1'b1;
    @(posedge clk); #1;
    bus.cfg_commit = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b0 || fir_coef_we !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_flush_outputs: got busy=%b in_ready=%b we=%b, required 1 0 0",
               busy, bus.in_ready, fir_coef_we);
    end
    rst = 1'b0;
    wait_run(FLUSH_LEN, "reset_mid_flush");
    ref_coef[0] = 16'sd9;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus.cfg_commit = 1'b0;
    for (int i = 0; i < NTAPS; i++) begin
      vals_ramp[i] = 16'(i + 1);
      vals_ones[i] = 16'sd1;
      ref_coef[i]  = '0;
      ref_hist[i]  = '0;
    end

    test_reset();
    test_coef_load(vals_ramp, "load_ramp");
    test_impulse("impulse_ramp");
    test_coef_load(vals_ones, "load_ones");
    test_impulse("impulse_ones");
    test_gaps();
    test_cfg_priority();
    test_commit_in_run();
    test_reset_mid_flush();
    test_impulse("impulse_final");

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
